// File: rtl/mem_pkg.sv
// Shared types and helpers for the SRAM front end: arbitration mode,
// SRAM read latency and byte-enable to bit-mask expansion.
package mem_pkg;

   typedef enum logic {
      PRIO_RR    = 1'b0,
      PRIO_FIXED = 1'b1
   } prio_mode_e;

   localparam int SRAM_RD_LAT = 1;

   // Widest data path the expansion helper supports; callers size-cast down.
   localparam int MAX_DATA_W = 256;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   // Active-high byte enables in, active-low SRAM bit write enables out.
   function automatic logic [MAX_DATA_W-1:0] expand_be(input logic [MAX_BE_W-1:0] be);
      logic [MAX_DATA_W-1:0] mask;
      for (int b = 0; b < MAX_BE_W; b++) begin
         mask[b*8 +: 8] = {8{~be[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way combinational arbiter, round-robin from rr_ptr or fixed priority
// (index 0 highest). Grant is one-hot-or-zero and forced to zero in reset.
module rr_arbiter
   import mem_pkg::*;
#(
   parameter int         N    = 2,
   parameter prio_mode_e MODE = PRIO_RR
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] ptr_nxt;
   logic [PTR_W-1:0] ptr_eff;
   logic [2*N-1:0]   req_dbl;
   logic [2*N-1:0]   rot_dbl;
   logic [2*N-1:0]   oh_dbl;
   logic [N-1:0]     rot;
   logic [N-1:0]     oh;

   // Rotate requests so the search start sits at bit 0, isolate the lowest
   // set bit, then rotate the winner back to its real position.
   always_comb begin
      ptr_eff = (MODE == PRIO_FIXED) ? '0 : rr_ptr;
      req_dbl = {req, req};
      rot_dbl = req_dbl >> ptr_eff;
      rot     = rot_dbl[N-1:0];
      oh      = rot & (~rot + N'(1));
      oh_dbl  = {{N{1'b0}}, oh} << ptr_eff;
      gnt     = (oh_dbl[N-1:0] | oh_dbl[2*N-1:N]) & {N{rst}};
   end

   always_comb begin
      ptr_nxt = rr_ptr;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) ptr_nxt = PTR_W'((i + 1) % N);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rr_ptr <= '0;
      else      rr_ptr <= ptr_nxt;
   end

endmodule

// File: rtl/sram_arbiter.sv
// N-channel single-beat front end sharing one SRAM port: arbitration,
// request mux onto the active-low SRAM controls, and read-data return tag.
module sram_arbiter
   import mem_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 32,
   parameter int PRIO_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          req,
   input  logic [NUM_CH-1:0]          we,
   input  logic [NUM_CH*DATA_W/8-1:0] be,
   input  logic [NUM_CH*ADDR_W-1:0]   addr,
   input  logic [NUM_CH*DATA_W-1:0]   wdata,
   output logic [NUM_CH-1:0]          gnt,
   output logic [NUM_CH-1:0]          rvalid,
   output logic [DATA_W-1:0]          rdata,
   output logic                       CEB,
   output logic                       WEB,
   output logic [DATA_W-1:0]          BWEB,
   output logic [ADDR_W-1:0]          A,
   output logic [DATA_W-1:0]          DI,
   input  logic [DATA_W-1:0]          DO
);

   localparam int BE_W = DATA_W / 8;
   localparam prio_mode_e MODE = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;

   logic              sel_we;
   logic [BE_W-1:0]   sel_be;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [DATA_W-1:0] bweb_wr;
   logic [NUM_CH-1:0] rd_tag;

   rr_arbiter #(
      .N    (NUM_CH),
      .MODE (MODE)
   ) u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   // NOTE: every output of this block gets a default before the loop, so
   // no path leaves a value unassigned and no latch is inferred; the zero
   // defaults double as the idle-bus values for A and DI.
   always_comb begin
      sel_we    = 1'b0;
      sel_be    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) begin
            sel_we    = we[i];
            sel_be    = be[i*BE_W +: BE_W];
            sel_addr  = addr[i*ADDR_W +: ADDR_W];
            sel_wdata = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign bweb_wr = DATA_W'(expand_be(MAX_BE_W'(sel_be)));

   assign CEB  = ~|gnt;
   assign WEB  = ~sel_we;
   assign BWEB = sel_we ? bweb_wr : '1;
   assign A    = sel_addr;
   assign DI   = sel_wdata;

   // The SRAM returns data one edge after a read, so the tag lags by one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_tag <= '0;
      else      rd_tag <= gnt & ~we;
   end

   assign rvalid = rd_tag;
   assign rdata  = DO;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed vector table, an async-reset sequence,
// then randomized traffic scored against a transaction-level model.
module tb_sram_arbiter;

   localparam int NCH    = 2;
   localparam int AW     = 14;
   localparam int DW     = 32;
   localparam int N_RAND = 400;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    req;
   logic [NCH-1:0]    we;
   logic [NCH*4-1:0]  be;
   logic [NCH*AW-1:0] addr;
   logic [NCH*DW-1:0] wdata;
   logic [NCH-1:0]    gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic              CEB, WEB;
   logic [DW-1:0]     BWEB, DI, DO;
   logic [AW-1:0]     A;

   logic [NCH-1:0]    fp_gnt, fp_rvalid;
   logic [DW-1:0]     fp_rdata, fp_bweb, fp_di;
   logic              fp_ceb, fp_web;
   logic [AW-1:0]     fp_a;

   logic [DW-1:0]     sram [0:(1<<AW)-1];
   logic [DW-1:0]     ref_mem [0:63];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .CEB(CEB), .WEB(WEB), .BWEB(BWEB),
      .A(A), .DI(DI), .DO(DO)
   );

   sram_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_fp (
      .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
      .gnt(fp_gnt), .rvalid(fp_rvalid), .rdata(fp_rdata), .CEB(fp_ceb), .WEB(fp_web),
      .BWEB(fp_bweb), .A(fp_a), .DI(fp_di), .DO(DO)
   );

   // Behavioural SRAM macro: bit-masked write, registered read.
   always @(posedge clk) begin
      if (!CEB) begin
         if (!WEB) sram[A] = (sram[A] & BWEB) | (DI & ~BWEB);
         else      DO <= sram[A];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NCH-1:0] lowest_req(input logic [NCH-1:0] r, input logic rv);
      logic [NCH-1:0] g;
      g = '0;
      for (int i = NCH - 1; i >= 0; i--) if (r[i]) g = '0 | (NCH'(1) << i);
      return rv ? g : '0;
   endfunction

   typedef struct {
      logic          rst_v;
      logic [1:0]    req, we;
      logic [7:0]    be;
      logic [13:0]   a0, a1;
      logic [31:0]   d0, d1;
      logic [1:0]    gnt;
      logic [13:0]   a;
      logic [31:0]   di, bweb;
      logic [1:0]    rvalid;
      logic [31:0]   rdata;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] w,
                               input logic [7:0] b, input logic [13:0] a0, input logic [13:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] g,
                               input logic [13:0] ea, input logic [31:0] edi, input logic [31:0] ebw,
                               input logic [1:0] erv, input logic [31:0] erd);
      vec_t v;
      v.rst_v = r;  v.req = rq; v.we = w; v.be = b; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.gnt = g; v.a = ea; v.di = edi; v.bweb = ebw; v.rvalid = erv; v.rdata = erd;
      return v;
   endfunction

   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   vec_t vt [24];

   // Randomized-phase request state: each channel holds its request until granted.
   logic        p_valid [NCH];
   logic        p_we    [NCH];
   logic [3:0]  p_be    [NCH];
   logic [13:0] p_addr  [NCH];
   logic [31:0] p_wd    [NCH];

   initial begin
      int          ptr, w, c;
      logic [1:0]  exp_rv, exp_gnt, cur_req;
      logic [31:0] exp_rd, exp_bweb;

      rst = 1'b0; req = '0; we = '0; be = '0; addr = '0; wdata = '0;
      for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
      sram[14'h0004] = 32'h1122_3344;
      sram[14'h0010] = 32'hDEAD_BEEF;

      //            rst req  we   be     a0     a1     d0            d1            gnt  A      DI            BWEB          rvalid rdata
      vt[0]  = mk(0, 2'b11, 2'b00, 8'h00, 14'h1,  14'h2,  32'h0,        32'h0,        2'b00, 14'h0,  32'h0,        ONES,         2'b00, 32'h0);
      vt[1]  = mk(1, 2'b11, 2'b00, 8'h00, 14'h4,  14'h10, 32'h5A5A0000, 32'h0,        2'b01, 14'h4,  32'h5A5A0000, ONES,         2'b00, 32'h0);
      vt[2]  = mk(1, 2'b10, 2'b00, 8'h00, 14'h4,  14'h10, 32'h0,        32'h12345678, 2'b10, 14'h10, 32'h12345678, ONES,         2'b01, 32'h11223344);
      vt[3]  = mk(1, 2'b00, 2'b00, 8'h00, 14'h0,  14'h0,  32'h0,        32'h0,        2'b00, 14'h0,  32'h0,        ONES,         2'b10, 32'hDEADBEEF);
      vt[4]  = mk(1, 2'b01, 2'b01, 8'h02, 14'h4,  14'h0,  32'h0000AB00, 32'h0,        2'b01, 14'h4,  32'h0000AB00, 32'hFFFF00FF, 2'b00, 32'h0);
      vt[5]  = mk(1, 2'b01, 2'b00, 8'h00, 14'h4,  14'h0,  32'h0,        32'h0,        2'b01, 14'h4,  32'h0,        ONES,         2'b00, 32'h0);
      vt[6]  = mk(1, 2'b00, 2'b00, 8'h00, 14'h0,  14'h0,  32'h0,        32'h0,        2'b00, 14'h0,  32'h0,        ONES,         2'b01, 32'h1122AB44);
      vt[7]  = mk(1, 2'b10, 2'b10, 8'hF0, 14'h0,  14'h20, 32'h0,        32'hCAFEF00D, 2'b10, 14'h20, 32'hCAFEF00D, 32'h0,        2'b00, 32'h0);
      vt[8]  = mk(1, 2'b10, 2'b00, 8'h00, 14'h0,  14'h20, 32'h0,        32'hCAFEF00D, 2'b10, 14'h20, 32'hCAFEF00D, ONES,         2'b00, 32'h0);
      vt[9]  = mk(1, 2'b00, 2'b00, 8'h00, 14'h0,  14'h0,  32'h0,        32'h0,        2'b00, 14'h0,  32'h0,        ONES,         2'b10, 32'hCAFEF00D);
      vt[10] = mk(1, 2'b01, 2'b01, 8'h00, 14'h4,  14'h0,  32'hFFFFFFFF, 32'h0,        2'b01, 14'h4,  32'hFFFFFFFF, ONES,         2'b00, 32'h0);
      vt[11] = mk(1, 2'b01, 2'b00, 8'h00, 14'h4,  14'h0,  32'h0,        32'h0,        2'b01, 14'h4,  32'h0,        ONES,         2'b00, 32'h0);
      vt[12] = mk(1, 2'b10, 2'b00, 8'h00, 14'h0,  14'h20, 32'h0,        32'h0,        2'b10, 14'h20, 32'h0,        ONES,         2'b01, 32'h1122AB44);
      vt[13] = mk(1, 2'b11, 2'b00, 8'h00, 14'h4,  14'h10, 32'h0,        32'h0,        2'b01, 14'h4,  32'h0,        ONES,         2'b10, 32'hCAFEF00D);
      vt[14] = mk(1, 2'b11, 2'b00, 8'h00, 14'h4,  14'h10, 32'h0,        32'h0,        2'b10, 14'h10, 32'h0,        ONES,         2'b01, 32'h1122AB44);
      vt[15] = mk(1, 2'b11, 2'b00, 8'h00, 14'h4,  14'h10, 32'h0,        32'h0,        2'b01, 14'h4,  32'h0,        ONES,         2'b10, 32'hDEADBEEF);
      vt[16] = mk(1, 2'b11, 2'b00, 8'h00, 14'h4,  14'h10, 32'h0,        32'h0,        2'b10, 14'h10, 32'h0,        ONES,         2'b01, 32'h1122AB44);
      vt[17] = mk(1, 2'b11, 2'b00, 8'h00, 14'h4,  14'h10, 32'h0,        32'h0,        2'b01, 14'h4,  32'h0,        ONES,         2'b10, 32'hDEADBEEF);
      vt[18] = mk(1, 2'b11, 2'b00, 8'h00, 14'h4,  14'h10, 32'h0,        32'h0,        2'b10, 14'h10, 32'h0,        ONES,         2'b01, 32'h1122AB44);
      vt[19] = mk(1, 2'b00, 2'b00, 8'h00, 14'h0,  14'h0,  32'h0,        32'h0,        2'b00, 14'h0,  32'h0,        ONES,         2'b10, 32'hDEADBEEF);
      vt[20] = mk(1, 2'b01, 2'b00, 8'h00, 14'h10, 14'h0,  32'h0,        32'h0,        2'b01, 14'h10, 32'h0,        ONES,         2'b00, 32'h0);
      vt[21] = mk(0, 2'b00, 2'b00, 8'h00, 14'h0,  14'h0,  32'h0,        32'h0,        2'b00, 14'h0,  32'h0,        ONES,         2'b00, 32'h0);
      vt[22] = mk(1, 2'b01, 2'b00, 8'h00, 14'h10, 14'h0,  32'h0,        32'h0,        2'b01, 14'h10, 32'h0,        ONES,         2'b00, 32'h0);
      vt[23] = mk(1, 2'b00, 2'b00, 8'h00, 14'h0,  14'h0,  32'h0,        32'h0,        2'b00, 14'h0,  32'h0,        ONES,         2'b01, 32'hDEADBEEF);

      // Directed table: inputs change 1 ns after the edge, outputs sampled mid-cycle.
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         rst = vt[i].rst_v; req = vt[i].req; we = vt[i].we; be = vt[i].be;
         addr = {vt[i].a1, vt[i].a0}; wdata = {vt[i].d1, vt[i].d0};
         #3;
         check($sformatf("v%0d gnt", i),    64'(gnt),    64'(vt[i].gnt));
         check($sformatf("v%0d CEB", i),    64'(CEB),    64'(~|vt[i].gnt));
         check($sformatf("v%0d WEB", i),    64'(WEB),    64'(~|(vt[i].gnt & vt[i].we)));
         check($sformatf("v%0d BWEB", i),   64'(BWEB),   64'(vt[i].bweb));
         check($sformatf("v%0d A", i),      64'(A),      64'(vt[i].a));
         check($sformatf("v%0d DI", i),     64'(DI),     64'(vt[i].di));
         check($sformatf("v%0d rvalid", i), 64'(rvalid), 64'(vt[i].rvalid));
         if (vt[i].rvalid != 2'b00) check($sformatf("v%0d rdata", i), 64'(rdata), 64'(vt[i].rdata));
         check($sformatf("v%0d fp_gnt", i), 64'(fp_gnt), 64'(lowest_req(vt[i].req, vt[i].rst_v)));
      end

      // Reset dropped mid-cycle during a granted read: outputs idle at once,
      // no rvalid follows, and arbitration restarts from ch0.
      @(posedge clk); #1;
      req = 2'b01; we = 2'b00; be = '0; addr = {14'h0, 14'h10}; wdata = '0;
      #1;
      check("async gnt before", 64'(gnt), 64'(2'b01));
      rst = 1'b0;
      #1;
      check("async gnt", 64'(gnt), 64'(2'b00));
      check("async CEB", 64'(CEB), 64'(1'b1));
      check("async A",   64'(A),   64'(14'h0));
      @(posedge clk); #1;
      check("async rvalid", 64'(rvalid), 64'(2'b00));
      rst = 1'b1; req = '0;
      #3;
      check("async rvalid after release", 64'(rvalid), 64'(2'b00));

      // Randomized traffic against a transaction-level model.
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      ref_mem[4]  = 32'h1122_AB44;
      ref_mem[16] = 32'hDEAD_BEEF;
      ref_mem[32] = 32'hCAFE_F00D;
      for (int k = 0; k < NCH; k++) p_valid[k] = 1'b0;
      ptr = 0; exp_rv = '0; exp_rd = '0;

      for (int cyc = 0; cyc < N_RAND + 4; cyc++) begin
         @(posedge clk); #1;
         for (int k = 0; k < NCH; k++) begin
            if (!p_valid[k] && cyc < N_RAND && $urandom_range(0, 3) != 0) begin
               p_valid[k] = 1'b1;
               p_we[k]    = 1'($urandom_range(0, 1));
               p_be[k]    = 4'($urandom_range(0, 15));
               p_addr[k]  = 14'($urandom_range(0, 63));
               p_wd[k]    = $urandom;
            end
            req[k] = p_valid[k];
            we[k]  = p_valid[k] ? p_we[k] : 1'b0;
            be[k*4 +: 4]     = p_be[k];
            addr[k*AW +: AW] = p_addr[k];
            wdata[k*DW +: DW] = p_wd[k];
         end
         #3;
         w = -1;
         for (int off = 0; off < NCH; off++) begin
            c = (ptr + off) % NCH;
            if (w < 0 && p_valid[c]) w = c;
         end
         exp_gnt = (w < 0) ? 2'b00 : 2'(1 << w);
         exp_bweb = ONES;
         if (w >= 0 && p_we[w])
            for (int b = 0; b < 4; b++) exp_bweb[b*8 +: 8] = p_be[w][b] ? 8'h00 : 8'hFF;
         cur_req = req;
         check("rnd gnt",    64'(gnt),    64'(exp_gnt));
         check("rnd CEB",    64'(CEB),    64'(w < 0));
         check("rnd WEB",    64'(WEB),    64'(!(w >= 0 && p_we[w])));
         check("rnd BWEB",   64'(BWEB),   64'(exp_bweb));
         check("rnd A",      64'(A),      (w < 0) ? 64'h0 : 64'(p_addr[w]));
         check("rnd DI",     64'(DI),     (w < 0) ? 64'h0 : 64'(p_wd[w]));
         check("rnd rvalid", 64'(rvalid), 64'(exp_rv));
         if (exp_rv != 2'b00) check("rnd rdata", 64'(rdata), 64'(exp_rd));
         check("rnd fp_gnt", 64'(fp_gnt), 64'(lowest_req(cur_req, 1'b1)));

         exp_rv = '0;
         if (w >= 0) begin
            ptr = (w + 1) % NCH;
            if (p_we[w]) begin
               for (int b = 0; b < 4; b++)
                  if (p_be[w][b]) ref_mem[p_addr[w][5:0]][b*8 +: 8] = p_wd[w][b*8 +: 8];
            end else begin
               exp_rv = exp_gnt;
               exp_rd = ref_mem[p_addr[w][5:0]];
            end
            p_valid[w] = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Parametrised N-channel front end that shares one SRAM_wrapper port among several requesters, replacing the fixed one-master-per-macro arrangement of the current top level. Each channel issues single-beat read/write requests with a req/gnt handshake; the block arbitrates round-robin or fixed-priority, drives the active-low SRAM controls, and routes 1-cycle-latency read data back with a per-channel valid. Intended first use: IM and DM traffic from the CPU sharing one macro, with a DMA channel added later.

## Interface
- NUM_CH, 2, number of requesting channels (1..8)
- ADDR_W, 14, word address width
- DATA_W, 32, data width; multiple of 8
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (ch0 highest)

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_CH  per-channel request, held until gnt
- we  in  NUM_CH  1 = write, 0 = read
- be  in  NUM_CH*DATA_W/8  byte enables, active high, writes only
- addr  in  NUM_CH*ADDR_W  word address per channel
- wdata  in  NUM_CH*DATA_W  write data per channel
- gnt  out  NUM_CH  one-hot-or-zero grant, same cycle as accepted req
- rvalid  out  NUM_CH  read data valid for that channel, one cycle after its read gnt
- rdata  out  DATA_W  shared read data, meaningful only when some rvalid is high
- CEB  out  1  SRAM chip enable, active low
- WEB  out  1  SRAM write enable, active low (high = read)
- BWEB  out  DATA_W  SRAM bit write enable, active low
- A  out  ADDR_W  SRAM address
- DI  out  DATA_W  SRAM write data
- DO  in  DATA_W  SRAM read data, valid the cycle after a read edge

## Operation
- Arbitration combinational each cycle over req; at most one gnt bit high; gnt only to a requesting channel.
- Round-robin: search starts at pointer rr_ptr; on any grant to channel k, rr_ptr <= (k+1) mod NUM_CH; no grant -> rr_ptr holds. Reset rr_ptr = 0.
- Fixed priority: lowest requesting index wins; rr_ptr unused.
- Granted channel drives SRAM: CEB=0, WEB=~we[k], A=addr[k], DI=wdata[k], BWEB = bitwise-expanded ~be[k] for writes, all ones for reads.
- No grant: CEB=1, WEB=1, BWEB all ones, A and DI = 0.
- Read tag register: on read grant to k, rd_tag <= one-hot k, else 0. rvalid = rd_tag. rdata = DO.
- Writes produce no rvalid; write is complete at the granting edge.
- Back-to-back: a channel may be granted every cycle; a read granted in cycle n+1 after a write to the same address in cycle n returns the new data.
- be = 0 on a write: SRAM still enabled with BWEB all ones; memory unchanged; gnt still given.
- NUM_CH = 1: arbiter degenerates to gnt = req.

## Timing
- Request-to-grant: 0 cycles (combinational). Read grant to rvalid: exactly 1 cycle.
- Full throughput: one access per cycle, independent of channel mix.
- Reset asserted (rst=0), immediately and asynchronously: gnt=0, rvalid=0, CEB=1, WEB=1, BWEB all ones, A=0, DI=0, rd_tag=0, rr_ptr=0. rdata follows DO (don't-care).
- Reset asserted with a read in flight: that rvalid is never issued; requester must reissue.
- First cycle after reset release: arbitration resumes from ch0.

## Structure
- Package mem_pkg: prio_mode_e (PRIO_RR, PRIO_FIXED), function expand_be(be) -> active-low bit mask, SRAM latency constant SRAM_RD_LAT = 1.
- Sub-module rr_arbiter (parameter N, MODE): req in, gnt out, internal rr_ptr; reusable for future bus interconnect.
- Top-level sram_arbiter holds mux, BWEB expansion and rd_tag.

## Test plan
- Reset: rst=0 with req=2'b11 -> gnt=0, CEB=1, BWEB=32'hFFFFFFFF, rvalid=0; release -> ch0 granted first.
- Single read: ch1 reads addr 14'h0010 (preloaded 32'hDEADBEEF) -> gnt=2'b10 same cycle, next cycle rvalid=2'b10, rdata=32'hDEADBEEF.
- Byte write: ch0 write addr 14'h0004, be=4'b0010, wdata=32'h0000AB00 over 32'h11223344 -> BWEB=32'hFFFF00FF; readback 32'h1122AB44.
- Round-robin: both channels request reads continuously for 6 cycles -> gnt alternates 01,10,01,10,01,10; rvalid follows 1 cycle later. PRIO_MODE=1 -> gnt=01 every cycle.
- Write-then-read same address in consecutive cycles (32'hCAFEF00D to 14'h0020) -> read returns 32'hCAFEF00D.
- Reset mid-read: rst=0 for one cycle right after a read grant -> no rvalid issued; next read after release completes normally.
